// File: rtl/ps2_rx_frame_pkg.sv
// Shared definitions for the PS/2 device-to-host frame receiver:
// state encoding, error codes and frame geometry.
package ps2_rx_frame_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } rx_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_FRAME   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    // Bit counter values after the start bit: 0..7 data, 8 parity, 9 stop.
    localparam logic [3:0] PARITY_IDX = 4'(DATA_BITS);
    localparam logic [3:0] STOP_IDX   = 4'(FRAME_BITS - 2);

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// Frames the filtered PS/2 clock/data stream into bytes, checks parity, stop bit
// and inter-edge timeout, and hands good bytes to a valid/ack holding register.
module ps2_rx_frame
    import ps2_rx_frame_pkg::*;
#(
    parameter int TIMEOUT_COUNT = 2000,
    parameter int TIMER_WIDTH   = 12
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_en,
    input  logic       CLK_READY,
    input  logic       DATA_READY,
    input  logic       PS2_CLK_F,
    input  logic       PS2_DATA_F,
    input  logic       RX_ACK,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       OVERRUN,
    output logic       ERROR_PULSE,
    output logic [1:0] ERROR_CODE,
    output logic       BUSY
);

    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_VAL = TIMER_WIDTH'(TIMEOUT_COUNT);
    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE   = TIMER_WIDTH'(1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX   = '1;

    rx_state_t              state_q,     state_d;
    logic                   prev_clk_q,  prev_clk_d;
    logic [3:0]             bit_cnt_q,   bit_cnt_d;
    logic [TIMER_WIDTH-1:0] timer_q,     timer_d;
    logic [7:0]             shift_q,     shift_d;
    logic                   parity_q,    parity_d;
    logic [7:0]             rx_data_q,   rx_data_d;
    logic                   rx_valid_q,  rx_valid_d;
    logic                   overrun_q,   overrun_d;
    logic                   err_pulse_q, err_pulse_d;
    logic [1:0]             err_code_q,  err_code_d;

    logic                   rdy;
    logic                   fall;
    logic                   good_byte;
    logic [TIMER_WIDTH-1:0] timer_inc;

    always_comb begin
        rdy  = CLK_READY & DATA_READY;
        fall = rdy & prev_clk_q & ~PS2_CLK_F;

        state_d     = state_q;
        prev_clk_d  = PS2_CLK_F;
        bit_cnt_d   = bit_cnt_q;
        timer_d     = timer_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        good_byte   = 1'b0;
        timer_inc   = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_ONE;

        if (RX_ACK && rx_valid_q) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end

        if (!rdy) begin
            state_d = IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    timer_d = '0;
                    // A fall with data high is a glitch, not a start bit.
                    if (fall && !PS2_DATA_F) begin
                        state_d   = RECEIVE;
                        bit_cnt_d = '0;
                    end
                end
                RECEIVE: begin
                    if (fall) begin
                        timer_d   = '0;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q < PARITY_IDX) begin
                            shift_d = {PS2_DATA_F, shift_q[7:1]};
                        end else if (bit_cnt_q == PARITY_IDX) begin
                            parity_d = PS2_DATA_F;
                        end else if (bit_cnt_q == STOP_IDX) begin
                            state_d = IDLE;
                            if (!PS2_DATA_F) begin
                                err_pulse_d = 1'b1;
                                err_code_d  = ERR_FRAME;
                            end else if (!odd_parity_ok(shift_q, parity_q)) begin
                                err_pulse_d = 1'b1;
                                err_code_d  = ERR_PARITY;
                            end else begin
                                good_byte = 1'b1;
                            end
                        end
                    end else if (CLK_en) begin
                        timer_d = timer_inc;
                        if (timer_inc >= TIMEOUT_VAL) begin
                            state_d     = IDLE;
                            err_pulse_d = 1'b1;
                            err_code_d  = ERR_TIMEOUT;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // An ack in the same cycle frees the register, so the new byte lands cleanly.
        if (good_byte) begin
            if (!rx_valid_q || RX_ACK) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            prev_clk_q  <= 1'b1;
            bit_cnt_q   <= '0;
            timer_q     <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            prev_clk_q  <= prev_clk_d;
            bit_cnt_q   <= bit_cnt_d;
            timer_q     <= timer_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
        end
    end

    assign RX_DATA     = rx_data_q;
    assign RX_VALID    = rx_valid_q;
    assign OVERRUN     = overrun_q;
    assign ERROR_PULSE = err_pulse_q;
    assign ERROR_CODE  = err_code_q;
    assign BUSY        = (state_q == RECEIVE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Bench for ps2_rx_frame: bit-level PS/2 frame driver, byte and error-code
// scoreboards, and one task per scenario.
module tb_ps2_rx_frame;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_en = 1'b0;
  logic       clk_ready = 1'b1;
  logic       data_ready = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       error_pulse;
  logic [1:0] error_code;
  logic       busy;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q[$];
  logic [1:0] err_q[$];
  logic       prev_pulse = 1'b0;

  ps2_rx_frame #(.TIMEOUT_COUNT(8), .TIMER_WIDTH(12)) dut (
    .CLK(clk),
    .RESET(reset),
    .CLK_en(clk_en),
    .CLK_READY(clk_ready),
    .DATA_READY(data_ready),
    .PS2_CLK_F(ps2_clk),
    .PS2_DATA_F(ps2_data),
    .RX_ACK(rx_ack),
    .RX_DATA(rx_data),
    .RX_VALID(rx_valid),
    .OVERRUN(overrun),
    .ERROR_PULSE(error_pulse),
    .ERROR_CODE(error_code),
    .BUSY(busy)
  );

  // clock / strobe
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      clk_en = ~clk_en;
    end
  end

  // error scoreboard: every pulse must match a queued expected code
  always @(negedge clk) begin
    if (error_pulse === 1'b1) begin
      total++;
      if (err_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_error_pulse: code=%b, none expected", error_code);
      end else begin
        logic [1:0] e;
        e = err_q.pop_front();
        if (error_code !== e) begin
          bad++;
          $display("FAIL error_code: got=%b want=%b", error_code, e);
        end
      end
      total++;
      if (prev_pulse === 1'b1) begin
        bad++;
        $display("FAIL error_pulse_width: got=2+ cycles want=1");
      end
    end
    prev_pulse = error_pulse;
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx,
                                     input logic par_flip, input logic stop);
    logic par;
    par = ~(^b) ^ par_flip;
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else if (idx == 9) return par;
    else return stop;
  endfunction

  task automatic send_bit(input logic b, input logic ack);
    ps2_data = b;
    ps2_clk  = 1'b1;
    cyc(4);
    ps2_clk = 1'b0;
    rx_ack  = ack;
    cyc(1);
    rx_ack = 1'b0;
    cyc(3);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop,
                            input int nbits, input logic ack_last);
    for (int i = 0; i < nbits; i++) begin
      send_bit(frame_bit(b, i, par_flip, stop), (i == 10) ? ack_last : 1'b0);
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cyc(4);
  endtask

  task automatic do_ack;
    rx_ack = 1'b1;
    cyc(1);
    rx_ack = 1'b0;
    @(negedge clk);
    total++;
    if (rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL ack_clears_valid: got=%b want=0", rx_valid);
    end
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL ack_clears_overrun: got=%b want=0", overrun);
    end
    cyc(1);
  endtask

  task automatic check_byte(input string name);
    logic [7:0] e;
    @(negedge clk);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      if (rx_valid !== 1'b1 || rx_data !== e) begin
        bad++;
        $display("FAIL %s: got valid=%b data=%h want valid=1 data=%h", name, rx_valid, rx_data, e);
      end
    end
    cyc(1);
  endtask

  // scenarios
  task automatic test_reset;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({rx_data, rx_valid, overrun, error_pulse, error_code, busy} !== 14'h0) begin
      bad++;
      $display("FAIL reset_values: got data=%h v=%b ov=%b ep=%b ec=%b busy=%b want all 0",
               rx_data, rx_valid, overrun, error_pulse, error_code, busy);
    end
    cyc(2);
  endtask

  task automatic test_good;
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 10, 1'b0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL good_busy: got=%b want=1", busy);
    end
    ps2_data = 1'b1;
    ps2_clk  = 1'b1;
    cyc(4);
    ps2_clk = 1'b0;
    @(negedge clk);
    total++;
    if (rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL good_latency_early: got valid=%b want=0", rx_valid);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL good_busy_end: got=%b want=0", busy);
    end
    check_byte("good_1c");
    ps2_clk = 1'b1;
    cyc(4);
    do_ack();
  endtask

  task automatic test_parity;
    err_q.push_back(2'b01);
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
    @(negedge clk);
    total++;
    if (rx_valid !== 1'b0 || error_code !== 2'b01 || err_q.size() != 0) begin
      bad++;
      $display("FAIL parity_err: got valid=%b code=%b pending=%0d want 0/01/0",
               rx_valid, error_code, err_q.size());
    end
    cyc(1);
  endtask

  task automatic test_framing;
    for (int k = 0; k < 2; k++) begin
      err_q.push_back(2'b10);
      send_frame(8'h1C, k[0], 1'b0, 11, 1'b0);
      @(negedge clk);
      total++;
      if (rx_valid !== 1'b0 || error_code !== 2'b10 || err_q.size() != 0) begin
        bad++;
        $display("FAIL framing_err%0d: got valid=%b code=%b pending=%0d want 0/10/0",
                 k, rx_valid, error_code, err_q.size());
      end
      cyc(1);
    end
  endtask

  task automatic test_timeout;
    int waited;
    err_q.push_back(2'b11);
    for (int i = 0; i < 5; i++) send_bit(frame_bit(8'h1C, i, 1'b0, 1'b1), 1'b0);
    ps2_clk = 1'b1;
    cyc(7);
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_early: got busy=%b want=1", busy);
    end
    waited = 0;
    while (busy === 1'b1 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    cyc(2);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || error_code !== 2'b11 || err_q.size() != 0) begin
      bad++;
      $display("FAIL timeout: got busy=%b code=%b pending=%0d want 0/11/0",
               busy, error_code, err_q.size());
    end
    cyc(2);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b0, 1'b1, 11, 1'b0);
    check_byte("after_timeout_55");
    do_ack();
  endtask

  task automatic test_overrun;
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    check_byte("overrun_keeps_f0");
    @(negedge clk);
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_set: got=%b want=1", overrun);
    end
    cyc(1);
    do_ack();
    exp_q.push_back(8'hF0);
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0);
    check_byte("second_f0");
    exp_q.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1);
    check_byte("ack_in_eval_1c");
    @(negedge clk);
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL ack_in_eval_overrun: got=%b want=0", overrun);
    end
    cyc(1);
    do_ack();
  endtask

  task automatic test_not_ready;
    clk_ready = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    clk_ready = 1'b1;
    cyc(2);
    @(negedge clk);
    total++;
    if (rx_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL not_ready_ignored: got valid=%b busy=%b want 0/0", rx_valid, busy);
    end
    cyc(1);
    for (int i = 0; i < 5; i++) send_bit(frame_bit(8'h1C, i, 1'b0, 1'b1), 1'b0);
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_busy_before: got=%b want=1", busy);
    end
    cyc(1);
    data_ready = 1'b0;
    cyc(1);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy_after: got=%b want=0", busy);
    end
    cyc(2);
    data_ready = 1'b1;
    cyc(30);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_silent: got busy=%b valid=%b want 0/0", busy, rx_valid);
    end
    cyc(1);
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1, 11, 1'b0);
    check_byte("after_abort_a5");
    do_ack();
  endtask

  initial begin
    test_reset();
    test_good();
    test_parity();
    test_framing();
    test_timeout();
    test_overrun();
    test_not_ready();
    cyc(4);
    total++;
    if (exp_q.size() != 0 || err_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: bytes=%0d errors=%0d want 0/0", exp_q.size(), err_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
